// File: rtl/exec_alu_pipe.sv
// exec_alu_pipe: single-cycle ALU with registered result/status and architectural NZCV flags.
// Define ALU_MUL_EN to add an iterative shift-add multiplier (opcode 1010); otherwise 1010 is undefined.
module exec_alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       command,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;

  logic             accept;
  logic             single_load;
  logic             alu_defined;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_status;
  logic [WIDTH:0]   ext_sum;
  logic             c_out;
  logic             v_out;

  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    mul_count;
  logic [WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0] mul_mplier;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_sum;
  logic             mul_s;
  logic             start_mul;
  logic             mul_done;

  assign in_ready    = rst && !flush && (state == IDLE) && (!out_valid || out_ready);
  assign start_mul   = accept && (command == OP_MUL);
  assign single_load = accept && !start_mul;
  assign mul_done    = (state == MUL_BUSY) && (mul_count == CW'(WIDTH - 1));
  assign mul_sum     = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_mul) next_state = MUL_BUSY;
      MUL_BUSY: if (mul_done)  next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  // One multiplier bit per cycle: multiplicand shifts up while the multiplier shifts down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_count  <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_s      <= 1'b0;
    end else if (start_mul) begin
      mul_count  <= '0;
      mul_mcand  <= operand1;
      mul_mplier <= operand2;
      mul_acc    <= '0;
      mul_s      <= s_bit;
    end else if (state == MUL_BUSY) begin
      mul_count  <= mul_count + CW'(1);
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_acc    <= mul_sum;
    end
  end
`else
  assign in_ready    = rst && !flush && (!out_valid || out_ready);
  assign single_load = accept;
`endif

  // Carry-in for ADC/SBC reads the flags register before this edge, so dependent ops chain.
  always_comb begin
    alu_res     = '0;
    alu_defined = 1'b1;
    ext_sum     = '0;
    c_out       = flags[1];
    v_out       = flags[0];
    case (command)
      OP_ADD, OP_ADC: begin
        ext_sum = {1'b0, operand1} + {1'b0, operand2}
                + {{WIDTH{1'b0}}, (command == OP_ADC) ? flags[1] : 1'b0};
        alu_res = ext_sum[WIDTH-1:0];
        c_out   = ext_sum[WIDTH];
        v_out   = (operand1[MSB] == operand2[MSB]) && (alu_res[MSB] != operand1[MSB]);
      end
      OP_SUB, OP_SBC: begin
        ext_sum = {1'b0, operand1} + {1'b0, ~operand2}
                + {{WIDTH{1'b0}}, (command == OP_SBC) ? flags[1] : 1'b1};
        alu_res = ext_sum[WIDTH-1:0];
        c_out   = ext_sum[WIDTH];
        v_out   = (operand1[MSB] != operand2[MSB]) && (alu_res[MSB] != operand1[MSB]);
      end
      OP_MOV:  alu_res = operand2;
      OP_MVN:  alu_res = ~operand2;
      OP_AND:  alu_res = operand1 & operand2;
      OP_ORR:  alu_res = operand1 | operand2;
      OP_EOR:  alu_res = operand1 ^ operand2;
      default: alu_defined = 1'b0;
    endcase
    if (alu_defined) alu_status = {alu_res[MSB], (alu_res == '0), c_out, v_out};
    else             alu_status = {1'b0, 1'b1, flags[1], flags[0]};
  end

  // Flush outranks every load; an undefined opcode never touches the flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      status    <= '0;
      flags     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (single_load) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      status    <= alu_status;
      if (s_bit && alu_defined) flags <= alu_status;
`ifdef ALU_MUL_EN
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_sum;
      status    <= {mul_sum[MSB], (mul_sum == '0), flags[1], flags[0]};
      if (mul_s) flags <= {mul_sum[MSB], (mul_sum == '0), flags[1], flags[0]};
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_alu_pipe.sv
// tb_exec_alu_pipe: directed vectors with a scoreboard queue drained by an output monitor.
// Exercises the multiplier path when ALU_MUL_EN is defined.
module tb_exec_alu_pipe;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_UND = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  command = 4'b0;
  logic        s_bit = 1'b0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  status;
  logic [3:0]  flags;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  st;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  exec_alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .command(command), .s_bit(s_bit), .operand1(operand1), .operand2(operand2),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_output actual result=%0h required no output", result);
    end else begin
      e = sb.pop_front();
      check("sb_result", result, e.res);
      check("sb_status", status, e.st);
      check("sb_flags", flags, e.fl);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) checkOutput();
  end

  task automatic applyStimulus(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] er,
                               input logic [3:0] es, input logic [3:0] ef, input bit push);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    command = cmd; s_bit = s; operand1 = a; operand2 = b; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual in_ready=0 required in_ready=1");
    end else if (push) begin
      sb.push_back('{er, es, ef});
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_status", status, 0);
    check("rst_flags", flags, 0);
    check("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Back-to-back single-cycle ops; flags chain through ADC/SBC.
    applyStimulus(OP_ADD, 1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 4'b1001, 1);
    applyStimulus(OP_SUB, 1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 4'b0110, 1);
    applyStimulus(OP_SBC, 1, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0110, 4'b0110, 1);
    applyStimulus(OP_ADC, 1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0010, 4'b0010, 1);
    applyStimulus(OP_ADC, 0, 32'h00000001, 32'h00000001, 32'h00000003, 4'b0000, 4'b0010, 1);
    applyStimulus(OP_SUB, 1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, 4'b1000, 1);
    applyStimulus(OP_SBC, 1, 32'h0000000A, 32'h00000003, 32'h00000006, 4'b0010, 4'b0010, 1);
    applyStimulus(OP_SUB, 1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 4'b0011, 1);
    applyStimulus(OP_MOV, 1, 32'h12345678, 32'h00000000, 32'h00000000, 4'b0111, 4'b0111, 1);
    applyStimulus(OP_MVN, 0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 4'b1011, 4'b0111, 1);
    applyStimulus(OP_AND, 1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0011, 4'b0011, 1);
    applyStimulus(OP_ORR, 1, 32'h0F000000, 32'h80000001, 32'h8F000001, 4'b1011, 4'b1011, 1);
    applyStimulus(OP_UND, 1, 32'h11111111, 32'h22222222, 32'h00000000, 4'b0111, 4'b1011, 1);
    applyStimulus(OP_EOR, 1, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0111, 4'b0111, 1);
    applyStimulus(OP_ADD, 0, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0000, 4'b0111, 1);
    idle(2);

    // Flush beats a simultaneous request.
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; command = OP_ADD; s_bit = 1'b1;
    operand1 = 32'h1; operand2 = 32'h1;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_flags", flags, 4'b0111);

    // Backpressure holds the result and blocks new accepts.
    idle(2);
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 0, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 4'b0111, 1);
    @(posedge clk); #1;
    command = OP_ADD; s_bit = 1'b0; operand1 = 32'h4; operand2 = 32'h4; in_valid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_result", result, 32'h5);
      check("stall_out_valid", out_valid, 1);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    #1;
    check("resume_in_ready", in_ready, 1);
    sb.push_back('{32'h00000008, 4'b0000, 4'b0111});
    idle(2);

`ifdef ALU_MUL_EN
    applyStimulus(OP_MUL, 1, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 4'b1011, 4'b1011, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("mul_busy_out_valid", out_valid, 0);
      check("mul_busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    check("mul_done_out_valid", out_valid, 1);
    idle(2);

    // Flush in the tenth busy cycle kills the multiply and blocks the new request.
    applyStimulus(OP_MUL, 1, 32'h00000003, 32'h00000005, 32'h0, 4'b0, 4'b0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; command = OP_ADD; s_bit = 1'b1;
    operand1 = 32'h1; operand2 = 32'h1;
    #1;
    check("mulflush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("mulflush_out_valid", out_valid, 0);
    check("mulflush_flags", flags, 4'b1011);
    check("mulflush_idle", in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    check("mulflush_late_out_valid", out_valid, 0);
    check("mulflush_late_flags", flags, 4'b1011);
`else
    applyStimulus(OP_MUL, 1, 32'h0000FFFF, 32'h00010001, 32'h00000000, 4'b0111, 4'b0111, 1);
    idle(2);
`endif

    // Asynchronous reset mid-cycle while a result is held.
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 0, 32'h00000001, 32'h00000002, 32'h0, 4'b0, 4'b0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("held_out_valid", out_valid, 1);
    check("held_result", result, 32'h3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_status", status, 0);
    check("arst_flags", flags, 0);
    check("arst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;

    applyStimulus(OP_SBC, 1, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 4'b1000, 1);
    idle(3);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_alu_pipe.md
EXEC_ALU_PIPE -- requirements
Module: exec_alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operation presented.
REQ-005 in_ready  output  1  block accepts operation this cycle.
REQ-006 command  input  4  opcode (0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL).
REQ-007 s_bit  input  1  operation writes architectural flags.
REQ-008 operand1, operand2  input  WIDTH  source operands.
REQ-009 flush  input  1  synchronous pipeline kill.
REQ-010 out_valid  output  1  result register holds a valid result.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 status  output  4  registered {N,Z,C,V} computed for result.
REQ-014 flags  output  4  architectural {N,Z,C,V} register.

Function
REQ-015 Accept occurs when in_valid && in_ready; in_ready = !flush && state==IDLE && (!out_valid || out_ready).
REQ-016 Single-cycle ops: result/status/out_valid loaded on the accept edge; latency 1 cycle; back-to-back accept every cycle while out_ready=1.
REQ-017 out_valid clears on out_ready && !new load; result/status hold while out_valid && !out_ready.
REQ-018 ADD/ADC: sum = op1 + op2 (+ flags.C for ADC) in WIDTH+1 bits; C = bit WIDTH; V = signed overflow.
REQ-019 SUB/SBC: op1 - op2 (- !flags.C for SBC); C = NOT borrow (1 when no borrow); V = signed overflow.
REQ-020 MOV/MVN/AND/ORR/EOR (and MUL): N = result MSB, Z = (result==0); C and V copied from flags.
REQ-021 Undefined opcode: result 0, status = {0,1,flags.C,flags.V}; flags never updated.
REQ-022 On accept of a single-cycle op with s_bit=1, flags <= computed status on the same edge; carry-in for ADC/SBC is flags value before that edge, so consecutive dependent ops chain correctly.
REQ-023 Arithmetic wraps modulo 2^WIDTH; no saturation.
REQ-024 flush: out_valid <= 0, state <= IDLE, in-flight MUL discarded, flags not written by discarded op; flush beats simultaneous in_valid.

Reset
REQ-025 On rst low, immediately: out_valid=0, result=0, status=0, flags=0, state=IDLE, MUL counter=0; in_ready low while rst asserted.
REQ-026 Reset mid-MUL abandons it; no flag or output update after release.

Configuration
REQ-027 Macro ALU_MUL_EN defined: MUL (1010) implemented as iterative shift-add FSM IDLE->MUL_BUSY (WIDTH cycles, one bit per cycle)->IDLE, loading result (low WIDTH bits of product) and out_valid on final edge; latency WIDTH cycles from accept; in_ready=0 in MUL_BUSY; s_bit and operands latched at accept, flags written at completion.
REQ-028 Macro ALU_MUL_EN undefined: no MUL FSM or counter synthesised; 1010 treated as undefined opcode (REQ-021); state permanently IDLE.

Verification
REQ-029 WIDTH=32, ADD 0x7FFFFFFF+0x1, s_bit=1 -> next cycle result 0x80000000, status 1001, flags 1001.
REQ-030 SUB 5-5 s_bit=1 then SBC 0-0 -> first status 0110 (Z,C set); SBC result 0x00000000, C=1 (carry-in 1, no borrow).
REQ-031 out_ready=0 with result held, in_valid=1 -> in_ready=0, result stable for 5 cycles; out_ready=1 -> accept resumes next cycle.
REQ-032 With ALU_MUL_EN, MUL 0x0000FFFF*0x00010001, s_bit=1 -> out_valid exactly 32 cycles after accept, result 0xFFFFFFFF, N=1, C/V unchanged; in_ready 0 throughout.
REQ-033 flush asserted mid-MUL (cycle 10) with in_valid=1 -> no out_valid, flags unchanged, input not accepted that cycle, IDLE next cycle.
REQ-034 rst pulsed low asynchronously between edges while out_valid=1 -> outputs and flags 0 immediately, no clock required.
